// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source producing a pixel clock enable, pixel/line counters, blanking and line/frame markers.
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous active-high reset
//   o_ce_pix       one-clk pixel enable, once every CE_DIV clks
//   o_hcnt/o_vcnt  pixel and line counters, stable for the whole ce_pix cycle
//   o_hblank       high while o_hcnt >= H_ACTIVE
//   o_vblank       high while o_vcnt >= V_ACTIVE
//   o_line_start   coincident with ce_pix when o_hcnt == 0
//   o_frame_start  coincident with ce_pix when o_hcnt == 0 and o_vcnt == 0
//   o_frame_cnt    completed-frame counter, wraps silently
module video_timing_gen #(
    parameter int CE_DIV     = 4,
    parameter int H_TOTAL    = 384,
    parameter int H_ACTIVE   = 256,
    parameter int V_TOTAL    = 264,
    parameter int V_ACTIVE   = 224,
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_ce_pix,
    output logic [8:0] o_hcnt,
    output logic [8:0] o_vcnt,
    output logic       o_hblank,
    output logic       o_vblank,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_cnt
);
    localparam logic [3:0] CDIV_LAST = 4'(CE_DIV - 1);
    localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT     = 9'(H_ACTIVE);
    localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT     = 9'(V_ACTIVE);

    // The sync generator places its pulses inside blanking, so blanking must be wide enough.
    if (SYNC_CHECK && ((H_TOTAL - H_ACTIVE) < 45 || (V_TOTAL - V_ACTIVE) < 25)) begin : g_sync_chk
        $error("video_timing_gen: blanking too narrow for sync generator");
    end

    logic [3:0] r_cdiv;
    logic       r_ce;
    logic [8:0] r_hcnt;
    logic [8:0] r_vcnt;
    logic       r_hblank;
    logic       r_vblank;
    logic       r_line;
    logic       r_frame;
    logic [7:0] r_fcnt;

    logic       w_cdiv_last;
    logic       w_hlast;
    logic       w_vlast;
    logic [8:0] w_hnext;
    logic [8:0] w_vnext;
    logic [8:0] w_hafter;
    logic [8:0] w_vafter;

    assign w_cdiv_last = r_cdiv == CDIV_LAST;
    assign w_hlast     = r_hcnt == H_LAST;
    assign w_vlast     = r_vcnt == V_LAST;
    assign w_hnext     = w_hlast ? 9'd0 : r_hcnt + 9'd1;
    assign w_vnext     = w_hlast ? (w_vlast ? 9'd0 : r_vcnt + 9'd1) : r_vcnt;
    // Counter values that will hold during the next cycle; with CE_DIV=1 they
    // advance on the same edge that raises the markers.
    assign w_hafter    = r_ce ? w_hnext : r_hcnt;
    assign w_vafter    = r_ce ? w_vnext : r_vcnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cdiv   <= 4'd0;
            r_ce     <= 1'b0;
            r_hcnt   <= 9'd0;
            r_vcnt   <= 9'd0;
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
            r_line   <= 1'b0;
            r_frame  <= 1'b0;
            r_fcnt   <= 8'd0;
        end else begin
            r_cdiv  <= w_cdiv_last ? 4'd0 : r_cdiv + 4'd1;
            r_ce    <= w_cdiv_last;
            r_line  <= w_cdiv_last && w_hafter == 9'd0;
            r_frame <= w_cdiv_last && w_hafter == 9'd0 && w_vafter == 9'd0;
            if (r_ce) begin
                r_hcnt   <= w_hnext;
                r_vcnt   <= w_vnext;
                r_hblank <= w_hnext >= H_ACT;
                r_vblank <= w_vnext >= V_ACT;
                if (w_hlast && w_vlast)
                    r_fcnt <= r_fcnt + 8'd1;
            end
        end
    end

    assign o_ce_pix      = r_ce;
    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;
    assign o_hblank      = r_hblank;
    assign o_vblank      = r_vblank;
    assign o_line_start  = r_line;
    assign o_frame_start = r_frame;
    assign o_frame_cnt   = r_fcnt;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of default and small raster configurations.
module tb_video_timing_gen;
    logic       clk = 1'b0;
    logic       rst_d = 1'b1;
    logic       rst_s = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;

    logic       d_ce, d_hb, d_vb, d_ls, d_fs;
    logic [8:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       s_ce, s_hb, s_vb, s_ls, s_fs;
    logic [8:0] s_h, s_v;
    logic [7:0] s_fc;

    always #5 clk = ~clk;

    video_timing_gen u_def (
        .i_clk(clk), .i_reset(rst_d), .o_ce_pix(d_ce), .o_hcnt(d_h), .o_vcnt(d_v),
        .o_hblank(d_hb), .o_vblank(d_vb), .o_line_start(d_ls), .o_frame_start(d_fs),
        .o_frame_cnt(d_fc)
    );

    video_timing_gen #(
        .CE_DIV(1), .H_TOTAL(8), .H_ACTIVE(5), .V_TOTAL(4), .V_ACTIVE(2), .SYNC_CHECK(1'b0)
    ) u_small (
        .i_clk(clk), .i_reset(rst_s), .o_ce_pix(s_ce), .o_hcnt(s_h), .o_vcnt(s_v),
        .o_hblank(s_hb), .o_vblank(s_vb), .o_line_start(s_ls), .o_frame_start(s_fs),
        .o_frame_cnt(s_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Releases the default DUT from reset and checks its first full line.
    task automatic line_check(input string tag);
        int cyc, ce_n, hb_ce, rise_h, stab_bad, blank_bad, gap_bad, last_ce;
        logic p_ce, p_hb, p_vb;
        logic [8:0] p_h, p_v;
        @(negedge clk);
        rst_d = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk({tag, "_ce_edge"}, 32'(d_ce), 32'(e == 4));
        end
        chk({tag, "_first_ls"}, 32'(d_ls), 1);
        chk({tag, "_first_fs"}, 32'(d_fs), 1);
        chk({tag, "_first_h"}, 32'(d_h), 0);
        cyc = 0; ce_n = 1; hb_ce = 0; rise_h = -1;
        stab_bad = 0; blank_bad = 0; gap_bad = 0; last_ce = 0;
        p_ce = d_ce; p_hb = d_hb; p_vb = d_vb; p_h = d_h; p_v = d_v;
        while (cyc < 2000) begin
            tick();
            cyc++;
            if (!p_ce && (d_h !== p_h || d_v !== p_v || d_hb !== p_hb || d_vb !== p_vb))
                stab_bad++;
            if (d_hb !== (d_h >= 9'd256))
                blank_bad++;
            if (d_hb && !p_hb)
                rise_h = int'(d_h);
            if (d_ls)
                break;
            if (d_ce) begin
                ce_n++;
                if (d_hb)
                    hb_ce++;
                if (cyc - last_ce != 4)
                    gap_bad++;
                last_ce = cyc;
            end
            p_ce = d_ce; p_hb = d_hb; p_vb = d_vb; p_h = d_h; p_v = d_v;
        end
        chk({tag, "_line_clks"}, 32'(cyc), 1536);
        chk({tag, "_ce_per_line"}, 32'(ce_n), 384);
        chk({tag, "_hblank_ce"}, 32'(hb_ce), 128);
        chk({tag, "_hblank_rise_h"}, 32'(rise_h), 256);
        chk({tag, "_stability"}, 32'(stab_bad), 0);
        chk({tag, "_hblank_level"}, 32'(blank_bad), 0);
        chk({tag, "_ce_period"}, 32'(gap_bad), 0);
        chk({tag, "_ls_ce"}, 32'(d_ce), 1);
        chk({tag, "_l1_h"}, 32'(d_h), 0);
        chk({tag, "_l1_v"}, 32'(d_v), 1);
        chk({tag, "_l1_fs"}, 32'(d_fs), 0);
        chk({tag, "_l1_vb"}, 32'(d_vb), 0);
    endtask

    initial begin
        int found, ls_n, fs_n, fc32, fc33, bad_h, bad_v, bad_b, bad_ce, bad_m, bad_fc;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_ce", 32'(d_ce), 0);
        chk("rst_h", 32'(d_h), 0);
        chk("rst_v", 32'(d_v), 0);
        chk("rst_hb", 32'(d_hb), 0);
        chk("rst_vb", 32'(d_vb), 0);
        chk("rst_ls", 32'(d_ls), 0);
        chk("rst_fs", 32'(d_fs), 0);
        chk("rst_fc", 32'(d_fc), 0);

        line_check("first");

        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (d_ce && d_h == 9'd100) found = 1;
        end
        chk("reach_h100", 32'(found), 1);
        #3 rst_d = 1'b1;
        #1;
        chk("async_ce", 32'(d_ce), 0);
        chk("async_h", 32'(d_h), 0);
        chk("async_v", 32'(d_v), 0);
        chk("async_ls", 32'(d_ls), 0);
        chk("async_fc", 32'(d_fc), 0);
        line_check("rerun");

        chk("s_rst_ce", 32'(s_ce), 0);
        chk("s_rst_h", 32'(s_h), 0);
        @(negedge clk);
        rst_s = 1'b0;
        ls_n = 0; fs_n = 0; fc32 = -1; fc33 = -1;
        bad_h = 0; bad_v = 0; bad_b = 0; bad_ce = 0; bad_m = 0; bad_fc = 0;
        for (int k = 1; k <= 8193; k++) begin
            int eh, ev;
            tick();
            eh = (k - 1) % 8;
            ev = ((k - 1) / 8) % 4;
            if (int'(s_h) != eh) bad_h++;
            if (int'(s_v) != ev) bad_v++;
            if (s_hb !== (eh >= 5) || s_vb !== (ev >= 2)) bad_b++;
            if (s_ce !== 1'b1) bad_ce++;
            if (s_ls !== (eh == 0) || s_fs !== ((k - 1) % 32 == 0)) bad_m++;
            if (int'(s_fc) != ((k - 1) / 32) % 256) bad_fc++;
            if (k <= 8192 && s_ls) ls_n++;
            if (k <= 8192 && s_fs) fs_n++;
            if (k == 32) fc32 = int'(s_fc);
            if (k == 33) fc33 = int'(s_fc);
        end
        chk("s_hcnt_seq", 32'(bad_h), 0);
        chk("s_vcnt_seq", 32'(bad_v), 0);
        chk("s_blank", 32'(bad_b), 0);
        chk("s_ce_always", 32'(bad_ce), 0);
        chk("s_markers", 32'(bad_m), 0);
        chk("s_fc_seq", 32'(bad_fc), 0);
        chk("s_fc_before_wrap", 32'(fc32), 0);
        chk("s_fc_after_wrap", 32'(fc33), 1);
        chk("s_fc_256_wrap", 32'(s_fc), 0);
        chk("s_ls_count", 32'(ls_n), 1024);
        chk("s_fs_count", 32'(fs_n), 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Raster timing source for the arcade video path. Divides the system clock into a pixel clock enable. Runs horizontal and vertical pixel/line counters, and produces hblank/vblank plus line/frame markers. Sits directly upstream of the sync generator, which consumes ce_pix, hblank and vblank, and of the tile/sprite renderers, which consume hcnt/vcnt.

Parameters:
CE_DIV, 4, system clocks per pixel; legal range 1..16
H_TOTAL, 384, pixels per line including blanking; legal range 2..512
H_ACTIVE, 256, visible pixels per line; must satisfy 1 <= H_ACTIVE < H_TOTAL
V_TOTAL, 264, lines per frame including blanking; legal range 2..512
V_ACTIVE, 224, visible lines per frame; must satisfy 1 <= V_ACTIVE < V_TOTAL

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ce_pix  out  1  pixel clock enable; high for one clk in every CE_DIV clks
hcnt  out  9  horizontal pixel counter, 0..H_TOTAL-1
vcnt  out  9  vertical line counter, 0..V_TOTAL-1
hblank  out  1  high while hcnt >= H_ACTIVE
vblank  out  1  high while vcnt >= V_ACTIVE
line_start  out  1  high during the ce_pix cycle where hcnt==0
frame_start  out  1  high during the ce_pix cycle where hcnt==0 and vcnt==0
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high. All outputs are registered; there are no combinational paths from inputs.
- Reset values: internal divider=0, ce_pix=0, hcnt=0, vcnt=0, hblank=0, vblank=0, line_start=0, frame_start=0, frame_cnt=0.
- Divider:
  - 4-bit counter cdiv increments every clk and wraps CE_DIV-1 -> 0.
  - ce_pix is registered from (cdiv==CE_DIV-1).
  - Number the first rising edge after reset release as edge 1. ce_pix is first high after edge CE_DIV and stays high exactly one clk.
  - CE_DIV=1: ce_pix is 0 after reset, then high on every cycle from edge 1 onward.
- Counter advance:
  - hcnt, vcnt, hblank, vblank and frame_cnt update only on the clk edge that ends a cycle in which ce_pix==1.
  - They are therefore stable for the whole ce_pix cycle. Downstream blocks sample them qualified by ce_pix.
- Horizontal wrap: hcnt==H_TOTAL-1 -> 0, and the same edge advances the vertical counter.
- Vertical wrap: if vcnt==V_TOTAL-1 at a horizontal wrap, vcnt -> 0 and frame_cnt increments on the same edge. frame_cnt wraps 255 -> 0 silently.
- Blanking:
  - hblank and vblank are registered in the same update as the counters, computed from the next hcnt/vcnt values.
  - Blank levels are therefore never skewed from the counters.
  - hblank rises with hcnt = H_ACTIVE and falls with hcnt = 0. vblank rises with vcnt = V_ACTIVE and falls with vcnt = 0.
- Markers:
  - line_start = ce_pix && hcnt==0; frame_start = line_start && vcnt==0.
  - Both are registered so they are coincident with ce_pix, exactly one clk wide.
  - The first frame_start after reset occurs in the first ce_pix cycle, since counters reset to 0,0.
- Reset mid-operation: counters, divider and markers return to reset values immediately, asynchronously. No partial line or frame is completed. Timing restarts exactly as after power-up.
- Downstream sync constraint: the blanking intervals must cover the sync generator's pulse windows.
  - H_TOTAL-H_ACTIVE must be >= 45 pixels.
  - V_TOTAL-V_ACTIVE must be >= 25 lines.
  - Defaults give 128 pixels and 40 lines.
  - The implementation flags a violation with an elaboration-time check.
- Widths: all compares are unsigned 9-bit. Parameters are truncated to the port widths; no negative values exist.

Test Plan:
- Defaults, reset released: ce_pix first high after edge 4, then period 4 clk. Line length = 1536 clk. hblank high for exactly 128 ce_pix cycles, rising when hcnt=256.
- Defaults, one full frame: vblank rises at vcnt=224 and lasts 40 lines. Frame = 405504 clk. frame_start pulses once per frame. frame_cnt 0 -> 1 at the vcnt 263 -> 0 wrap.
- Small config (CE_DIV=1, H_TOTAL=8, H_ACTIVE=5, V_TOTAL=4, V_ACTIVE=2; sync constraint check disabled):
  - hcnt sequence 0..7 repeats; hblank=1 exactly when hcnt in 5..7.
  - vcnt 0..3; vblank=1 for lines 2..3.
  - ce_pix is high every cycle after edge 1.
- frame_cnt wrap, same small config: run 256 frames (8192 cycles). frame_cnt returns to 0, and line_start count = 1024.
- Assert reset mid-line at hcnt=100, vcnt=50, defaults: all outputs go to 0 without waiting for clk. After release, behaviour matches the first scenario cycle-for-cycle.
- Counter stability: across a full frame, hcnt/vcnt/hblank/vblank never change on an edge unless ce_pix was high in the preceding cycle.
